hazard_unit: RTL and testbench

- Pipeline control counterpart to the forwarding logic. It detects hazards that forwarding cannot resolve and produces the stall, bubble and flush controls for the 5-stage MIPS pipeline.
- Hazards covered: load-use, branch-in-ID operand dependency, taken-branch flush and data-memory wait.
- Contains a memory-wait FSM with timeout and saturating stall/flush performance counters.
- Sits in ID, beside the forwarding unit; drives PC, IF/ID and ID/EX register controls.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/sat_counter.sv | 29 ++
 rtl/hazard_unit.sv | 137 +++++++++++++
 tb/tb_hazard_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: memory-wait FSM states, register-index
// width and the "register 0 never matches" helper.
package cpu_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  // $zero is hard-wired, so a producer writing it never creates a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] a,
                                     input logic [REG_W-1:0] b);
    return (a != REG_ZERO) && (a == b);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a value on all paths,
  // otherwise synthesis infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  // NOTE: state flops use non-blocking assignment and an asynchronous
  // active-low reset so every flop in the block updates from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Stall/bubble/flush control for the 5-stage pipeline: load-use, branch-in-ID
// dependency, taken-branch squash and data-memory wait with timeout.
module hazard_unit
  import cpu_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] IF_ID_RegisterRs,
  input  logic [REG_W-1:0] IF_ID_RegisterRt,
  input  logic             IF_ID_UsesRt,
  input  logic             IF_ID_Branch,
  input  logic             Branch_Taken,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_RegWrite,
  input  logic [REG_W-1:0] ID_EX_RegisterRd,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic [REG_W-1:0] EX_MEM_RegisterRd,
  input  logic             dmem_ack_i,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Write,
  output logic             ID_EX_Flush,
  output logic             IF_ID_Flush,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);

  mem_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;

  logic memop, freeze, lu, bd;

  assign memop = EX_MEM_MemRead || EX_MEM_MemWrite;

  assign lu = ID_EX_MemRead &&
              (reg_match(ID_EX_RegisterRd, IF_ID_RegisterRs) ||
               (IF_ID_UsesRt && reg_match(ID_EX_RegisterRd, IF_ID_RegisterRt)));

  // A branch compares in ID, so it needs both operands regardless of UsesRt.
  assign bd = IF_ID_Branch &&
              ((ID_EX_RegWrite &&
                (reg_match(ID_EX_RegisterRd, IF_ID_RegisterRs) ||
                 reg_match(ID_EX_RegisterRd, IF_ID_RegisterRt))) ||
               (EX_MEM_MemRead &&
                (reg_match(EX_MEM_RegisterRd, IF_ID_RegisterRs) ||
                 reg_match(EX_MEM_RegisterRd, IF_ID_RegisterRt))));

  assign freeze = ((state_q == RUN) && memop && !dmem_ack_i) ||
                  ((state_q == MEM_WAIT) && !dmem_ack_i);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    case (state_q)
      RUN: begin
        if (memop && !dmem_ack_i) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ack_i)                    state_d    = RUN;
        else if (wait_cnt_q != TIMEOUT_V)  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
      default: state_d = RUN;
    endcase
    // The FSM keeps waiting after a timeout; only the sticky flag reports it.
    if ((state_d == MEM_WAIT) && (wait_cnt_d == TIMEOUT_V)) mem_err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Freeze outranks hazards, which outrank the taken-branch squash.
  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    EX_MEM_Write = 1'b1;
    MEM_WB_Write = 1'b1;
    ID_EX_Flush  = 1'b0;
    IF_ID_Flush  = 1'b0;
    if (rst_i) begin
      if (freeze) begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Write  = 1'b0;
        EX_MEM_Write = 1'b0;
        MEM_WB_Write = 1'b0;
      end else if (lu || bd) begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Flush  = 1'b1;
      end else if (Branch_Taken) begin
        IF_ID_Flush  = 1'b1;
      end
    end
  end

  assign mem_err_o = mem_err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (!PC_Write),
    .q     (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (IF_ID_Flush),
    .q     (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a driver pushes model expectations, a
// monitor pops and compares them at the falling edge.
module tb_hazard_unit;

  localparam int CNT_W   = 5;
  localparam int TIMEOUT = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] IF_ID_RegisterRs, IF_ID_RegisterRt, ID_EX_RegisterRd, EX_MEM_RegisterRd;
  logic       IF_ID_UsesRt, IF_ID_Branch, Branch_Taken;
  logic       ID_EX_MemRead, ID_EX_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite;
  logic       dmem_ack_i;
  logic       PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write;
  logic       ID_EX_Flush, IF_ID_Flush, mem_err_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  hazard_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .IF_ID_RegisterRs  (IF_ID_RegisterRs),
    .IF_ID_RegisterRt  (IF_ID_RegisterRt),
    .IF_ID_UsesRt      (IF_ID_UsesRt),
    .IF_ID_Branch      (IF_ID_Branch),
    .Branch_Taken      (Branch_Taken),
    .ID_EX_MemRead     (ID_EX_MemRead),
    .ID_EX_RegWrite    (ID_EX_RegWrite),
    .ID_EX_RegisterRd  (ID_EX_RegisterRd),
    .EX_MEM_MemRead    (EX_MEM_MemRead),
    .EX_MEM_MemWrite   (EX_MEM_MemWrite),
    .EX_MEM_RegisterRd (EX_MEM_RegisterRd),
    .dmem_ack_i        (dmem_ack_i),
    .PC_Write          (PC_Write),
    .IF_ID_Write       (IF_ID_Write),
    .ID_EX_Write       (ID_EX_Write),
    .EX_MEM_Write      (EX_MEM_Write),
    .MEM_WB_Write      (MEM_WB_Write),
    .ID_EX_Flush       (ID_EX_Flush),
    .IF_ID_Flush       (IF_ID_Flush),
    .mem_err_o         (mem_err_o),
    .stall_cnt_o       (stall_cnt_o),
    .flush_cnt_o       (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [6:0] ctl;   // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB writes, ID_EX_Flush, IF_ID_Flush}
    logic       err;
    int         stall;
    int         flush;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference state: are we waiting on memory, for how many cycles, etc.
  bit m_waiting = 0;
  int m_wait_len = 0;
  bit m_err = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  function automatic bit dep(input logic [4:0] producer, input logic [4:0] consumer);
    return (producer != 0) && (producer == consumer);
  endfunction

  // One clock cycle: inputs already set by caller.
  task automatic cycle();
    exp_t e;
    bit memop, freeze, hazard;
    memop  = EX_MEM_MemRead || EX_MEM_MemWrite;
    freeze = m_waiting ? !dmem_ack_i : (memop && !dmem_ack_i);
    hazard = (ID_EX_MemRead && (dep(ID_EX_RegisterRd, IF_ID_RegisterRs) ||
                                (IF_ID_UsesRt && dep(ID_EX_RegisterRd, IF_ID_RegisterRt)))) ||
             (IF_ID_Branch &&
              ((ID_EX_RegWrite && (dep(ID_EX_RegisterRd, IF_ID_RegisterRs) ||
                                   dep(ID_EX_RegisterRd, IF_ID_RegisterRt))) ||
               (EX_MEM_MemRead && (dep(EX_MEM_RegisterRd, IF_ID_RegisterRs) ||
                                   dep(EX_MEM_RegisterRd, IF_ID_RegisterRt)))));
    if (!rst_i) begin
      e.ctl = 7'b11111_00; e.err = 0; e.stall = 0; e.flush = 0;
    end else begin
      if (freeze)            e.ctl = 7'b00000_00;
      else if (hazard)       e.ctl = 7'b00111_10;
      else if (Branch_Taken) e.ctl = 7'b11111_01;
      else                   e.ctl = 7'b11111_00;
      e.err = m_err; e.stall = m_stall; e.flush = m_flush;
    end
    exp_q.push_back(e);
    @(posedge clk_i);
    if (!rst_i) begin
      m_waiting = 0; m_wait_len = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e.ctl[6]) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
      if (e.ctl[0])  m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
      if (!m_waiting) begin
        if (memop && !dmem_ack_i) begin m_waiting = 1; m_wait_len = 1; end
      end else if (dmem_ack_i) m_waiting = 0;
      else if (m_wait_len < TIMEOUT) m_wait_len++;
      if (m_waiting && m_wait_len >= TIMEOUT) m_err = 1;
    end
    #1;
  endtask

  task automatic idle();
    IF_ID_RegisterRs = 0; IF_ID_RegisterRt = 0; IF_ID_UsesRt = 0; IF_ID_Branch = 0;
    Branch_Taken = 0; ID_EX_MemRead = 0; ID_EX_RegWrite = 0; ID_EX_RegisterRd = 0;
    EX_MEM_MemRead = 0; EX_MEM_MemWrite = 0; EX_MEM_RegisterRd = 0; dmem_ack_i = 1;
  endtask

  // Monitor: every falling edge with a pending expectation is an output beat.
  initial begin
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("ctl", int'({PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                            MEM_WB_Write, ID_EX_Flush, IF_ID_Flush}), int'(e.ctl));
        check("mem_err", int'(mem_err_o), int'(e.err));
        check("stall_cnt", int'(stall_cnt_o), e.stall);
        check("flush_cnt", int'(flush_cnt_o), e.flush);
      end
    end
  end

  initial begin
    idle();
    rst_i = 0;
    @(posedge clk_i); #1;
    cycle(); cycle();
    rst_i = 1;

    // Load-use on rs: one bubble, then the load has moved to MEM.
    idle(); ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_RegisterRd = 2; IF_ID_RegisterRs = 2; cycle();
    idle(); EX_MEM_MemRead = 1; EX_MEM_RegisterRd = 2; IF_ID_RegisterRs = 2; cycle();
    // $0 never matches; unused rt never matches.
    idle(); ID_EX_MemRead = 1; ID_EX_RegisterRd = 0; IF_ID_RegisterRs = 0; cycle();
    idle(); ID_EX_MemRead = 1; ID_EX_RegisterRd = 5; IF_ID_RegisterRt = 5; IF_ID_RegisterRs = 1; cycle();
    // beq $3 behind add $3: one bubble.
    idle(); IF_ID_Branch = 1; IF_ID_RegisterRs = 3; ID_EX_RegWrite = 1; ID_EX_RegisterRd = 3; cycle();
    idle(); IF_ID_Branch = 1; IF_ID_RegisterRs = 3; EX_MEM_RegisterRd = 3; cycle();
    // beq $3 behind lw $3: two bubbles, then taken squash.
    idle(); IF_ID_Branch = 1; IF_ID_RegisterRt = 3; ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_RegisterRd = 3; cycle();
    idle(); IF_ID_Branch = 1; IF_ID_RegisterRt = 3; EX_MEM_MemRead = 1; EX_MEM_RegisterRd = 3; cycle();
    idle(); IF_ID_Branch = 1; IF_ID_RegisterRt = 3; Branch_Taken = 1; cycle();
    // Store waiting three cycles, then zero-wait store.
    idle(); EX_MEM_MemWrite = 1; dmem_ack_i = 0;
    repeat (3) cycle();
    dmem_ack_i = 1; cycle();
    cycle();
    // Freeze over load-use and taken branch.
    idle(); EX_MEM_MemRead = 1; EX_MEM_RegisterRd = 7; dmem_ack_i = 0;
    ID_EX_MemRead = 1; ID_EX_RegisterRd = 4; IF_ID_RegisterRs = 4; Branch_Taken = 1;
    cycle(); cycle();
    dmem_ack_i = 1; cycle();
    // Timeout, then reset mid-wait.
    idle(); EX_MEM_MemWrite = 1; dmem_ack_i = 0;
    repeat (7) cycle();
    rst_i = 0; cycle();
    rst_i = 1; cycle(); cycle();
    idle(); cycle();

    // Random traffic on a small register pool so dependencies are common.
    for (int i = 0; i < 600; i++) begin
      rst_i             = ($urandom_range(0, 99) != 0);
      IF_ID_RegisterRs  = 5'($urandom_range(0, 3));
      IF_ID_RegisterRt  = 5'($urandom_range(0, 3));
      ID_EX_RegisterRd  = 5'($urandom_range(0, 3));
      EX_MEM_RegisterRd = 5'($urandom_range(0, 3));
      IF_ID_UsesRt      = 1'($urandom_range(0, 1));
      IF_ID_Branch      = 1'($urandom_range(0, 1));
      Branch_Taken      = 1'($urandom_range(0, 1));
      ID_EX_MemRead     = 1'($urandom_range(0, 1));
      ID_EX_RegWrite    = 1'($urandom_range(0, 1));
      EX_MEM_MemRead    = ($urandom_range(0, 3) == 0);
      EX_MEM_MemWrite   = ($urandom_range(0, 3) == 0);
      dmem_ack_i        = (i % 100 > 90) ? 1'b0 : ($urandom_range(0, 2) != 0);
      cycle();
    end

    @(negedge clk_i); #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
